axi4_lite_master: RTL and testbench
===================================

# axi4_lite_master

Command-driven AXI4-Lite master that converts single read/write requests from a local client into AXI4-Lite transactions toward the RAM-side AXI4-Lite slave FSM. It sits directly upstream of the slave, driving the AR/R/AW/W/B channels, and returns read data and response codes to the client over a valid/ready response port. One transaction is outstanding at a time.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of cmd_addr / ARADDR / AWADDR
- DATA_WIDTH, 32, width of data buses; WSTRB is DATA_WIDTH/8

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  client request valid
- cmd_ready  out  1  master can accept a request
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  client accepts response
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  RRESP or BRESP captured from slave
- ARADDR out ADDR_WIDTH; ARVALID out 1; ARREADY in 1
- RDATA in DATA_WIDTH; RRESP in 2; RVALID in 1; RREADY out 1
- AWADDR out ADDR_WIDTH; AWVALID out 1; AWREADY in 1
- WDATA out DATA_WIDTH; WSTRB out DATA_WIDTH/8; WVALID out 1; WREADY in 1
- BRESP in 2; BVALID in 1; BREADY out 1

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- IDLE: cmd_ready=1. On cmd_valid: latch cmd_write, addr, wdata, wstrb; go to RD_ADDR (read) or WR_REQ (write).
- RD_ADDR: ARVALID=1, ARADDR=latched addr. On ARREADY -> RD_DATA.
- RD_DATA: RREADY=1. On RVALID: capture RDATA, RRESP -> RSP.
- WR_REQ: AWVALID and WVALID asserted together from entry. Separate aw_done/w_done flags; each VALID drops the cycle after its own handshake. Leave when both done (including same-cycle completion) -> WR_RESP. Slave may accept W only after AW; master must tolerate any order.
- WR_RESP: BREADY=1. On BVALID: capture BRESP, rsp_rdata=0 -> RSP.
- RSP: rsp_valid=1, outputs stable until rsp_ready; then -> IDLE.
- VALID signals never deassert before their handshake; ADDR/DATA/STRB stable while VALID high.
- rsp_resp passed through unmodified (SLVERR/DECERR not interpreted).
- Unused state encodings -> IDLE next cycle.

## Timing
- Reset (rst high at a clock edge): state=IDLE; next cycle cmd_ready=1, all other outputs 0 (ARVALID, AWVALID, WVALID, RREADY, BREADY, rsp_valid, data/addr/resp regs). Reset mid-transaction aborts immediately; system-level reset must also reset the slave.
- Outputs are registered-state decodes; no combinational path from AXI inputs to AXI outputs.
- Command accepted at edge N -> ARVALID/AWVALID/WVALID high from N+1.
- Read vs. single-cycle-ready slave: AR handshake edge N+1, RVALID at N+2, R handshake N+2, rsp_valid from N+3 (3-cycle latency).
- Write vs. slave accepting AW then W: AW edge N+1, W edge N+2, B edge N+3, rsp_valid from N+4.
- rsp_ready held high during RSP: next command accepted no earlier than one cycle after the response handshake (cmd_ready only in IDLE).
- cmd_valid while not in IDLE is ignored (not latched).

## Test plan
- Reset: rst high 2 cycles mid WR_REQ -> cycle after release cmd_ready=1, AWVALID=WVALID=rsp_valid=0.
- Read: cmd addr 0x10, slave returns RDATA 0xDEADBEEF, RRESP 0 -> ARADDR=0x10 from N+1, rsp_valid at N+3 with rsp_rdata=0xDEADBEEF, rsp_write=0.
- Write with slave ordering AW then W: addr 0x20, data 0x12345678, wstrb 0xF -> WVALID held until W handshake at N+2, BREADY at N+3, rsp_resp=0, rsp_write=1.
- Write with W accepted before AW, and with both in same cycle -> each VALID drops exactly after its own handshake, single B handshake, one response.
- Backpressure: RVALID delayed 5 cycles, rsp_ready low 4 cycles -> ARVALID/RREADY/rsp_* held stable, no second command accepted.
- Error: BRESP=2'b10 -> rsp_resp=2'b10; next read at 0x04 completes normally.

Source files
------------

// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: turns single client read/write commands into AXI4-Lite
// transactions and returns read data / response codes on a valid/ready port.
// Exactly one transaction is in flight at a time.
module axi4_lite_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   // client command port
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   // client response port
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   // read address channel
   output logic [ADDR_WIDTH-1:0]   ARADDR,
   output logic                    ARVALID,
   input  logic                    ARREADY,
   // read data channel
   input  logic [DATA_WIDTH-1:0]   RDATA,
   input  logic [1:0]              RRESP,
   input  logic                    RVALID,
   output logic                    RREADY,
   // write address channel
   output logic [ADDR_WIDTH-1:0]   AWADDR,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   // write data channel
   output logic [DATA_WIDTH-1:0]   WDATA,
   output logic [DATA_WIDTH/8-1:0] WSTRB,
   output logic                    WVALID,
   input  logic                    WREADY,
   // write response channel
   input  logic [1:0]              BRESP,
   input  logic                    BVALID,
   output logic                    BREADY
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4,
      RSP     = 3'd5
   } state_t;

   state_t                  state, state_next;
   logic                    write_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [STRB_WIDTH-1:0]   wstrb_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [1:0]              resp_q;
   logic                    aw_done, w_done;
   logic                    aw_hs, w_hs;
   logic                    aw_done_next, w_done_next;

   // All channel controls are pure decodes of registered state, so no AXI
   // input can reach an AXI output combinationally.
   assign cmd_ready = (state == IDLE);
   assign ARVALID   = (state == RD_ADDR);
   assign RREADY    = (state == RD_DATA);
   assign AWVALID   = (state == WR_REQ) && !aw_done;
   assign WVALID    = (state == WR_REQ) && !w_done;
   assign BREADY    = (state == WR_RESP);
   assign rsp_valid = (state == RSP);

   assign ARADDR    = addr_q;
   assign AWADDR    = addr_q;
   assign WDATA     = wdata_q;
   assign WSTRB     = wstrb_q;
   assign rsp_write = write_q;
   assign rsp_rdata = rdata_q;
   assign rsp_resp  = resp_q;

   // AW and W complete independently; either order or the same cycle is fine.
   assign aw_hs       = AWVALID && AWREADY;
   assign w_hs        = WVALID && WREADY;
   assign aw_done_next = aw_done || aw_hs;
   assign w_done_next  = w_done || w_hs;

   // State register; reset aborts any transaction in progress.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state decode; stray encodings fall back to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (cmd_valid) state_next = cmd_write ? WR_REQ : RD_ADDR;
         RD_ADDR: if (ARREADY) state_next = RD_DATA;
         RD_DATA: if (RVALID) state_next = RSP;
         WR_REQ:  if (aw_done_next && w_done_next) state_next = WR_RESP;
         WR_RESP: if (BVALID) state_next = RSP;
         RSP:     if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Command latch, per-channel write progress, and response capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         resp_q  <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  write_q <= cmd_write;
                  addr_q  <= cmd_addr;
                  wdata_q <= cmd_wdata;
                  wstrb_q <= cmd_wstrb;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
               end
            end
            RD_DATA: begin
               if (RVALID) begin
                  rdata_q <= RDATA;
                  resp_q  <= RRESP;
               end
            end
            WR_REQ: begin
               aw_done <= aw_done_next;
               w_done  <= w_done_next;
            end
            WR_RESP: begin
               if (BVALID) begin
                  rdata_q <= '0;
                  resp_q  <= BRESP;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: cycle-accurate slave driven from tasks, with a
// scoreboard of expected client responses popped as rsp_valid appears.
module tb_axi4_lite_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [7:0]  ARADDR, AWADDR;
   logic        ARVALID, ARREADY;
   logic [31:0] RDATA, WDATA;
   logic [1:0]  RRESP, BRESP;
   logic        RVALID, RREADY;
   logic        AWVALID, AWREADY;
   logic [3:0]  WSTRB;
   logic        WVALID, WREADY;
   logic        BVALID, BREADY;

   typedef struct packed {
      logic        wr;
      logic [31:0] rdata;
      logic [1:0]  resp;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   axi4_lite_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic quiet_inputs();
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      rsp_ready = 0; ARREADY = 0; RDATA = 0; RRESP = 0; RVALID = 0;
      AWREADY = 0; WREADY = 0; BRESP = 0; BVALID = 0;
   endtask

   task automatic drive_cmd(input logic wr, input logic [7:0] a,
                            input logic [31:0] d, input logic [3:0] s);
      cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
   endtask

   // Wait (bounded) for a response, pop the scoreboard, compare, then accept.
   task automatic wait_rsp();
      int   n = 0;
      exp_t e;
      while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      total++;
      if (rsp_valid !== 1'b1) begin
         $display("FAIL rsp_timeout rsp_valid=%0b required 1", rsp_valid);
         return;
      end
      passed++;
      total++;
      if (sb.size() == 0) begin
         $display("FAIL rsp_unexpected queue empty, got rdata=%h", rsp_rdata);
         return;
      end
      passed++;
      e = sb.pop_front();
      total++; if (rsp_write !== e.wr) $display("FAIL rsp_write got %0b required %0b", rsp_write, e.wr); else passed++;
      total++; if (rsp_rdata !== e.rdata) $display("FAIL rsp_rdata got %h required %h", rsp_rdata, e.rdata); else passed++;
      total++; if (rsp_resp !== e.resp) $display("FAIL rsp_resp got %0d required %0d", rsp_resp, e.resp); else passed++;
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      total++; if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL rsp_done {rsp_valid,cmd_ready} got %b required 01", {rsp_valid, cmd_ready}); else passed++;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      total++;
      if ({cmd_ready, ARVALID, AWVALID, WVALID, RREADY, BREADY, rsp_valid} !== 7'b1000000)
         $display("FAIL reset_ctl got %b required 1000000", {cmd_ready, ARVALID, AWVALID, WVALID, RREADY, BREADY, rsp_valid});
      else passed++;
      total++;
      if ({ARADDR, AWADDR, WDATA, WSTRB, rsp_rdata, rsp_resp, rsp_write} !== '0)
         $display("FAIL reset_data got addr=%h wdata=%h rdata=%h resp=%0d required 0", ARADDR, WDATA, rsp_rdata, rsp_resp);
      else passed++;
   endtask

   task automatic test_reset_mid_write();
      drive_cmd(1, 8'h44, 32'h1111_2222, 4'hF);
      @(negedge clk);
      cmd_valid = 0;
      total++; if (AWVALID !== 1'b1) $display("FAIL rst_mid_awvalid got %0b required 1", AWVALID); else passed++;
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      total++;
      if ({cmd_ready, AWVALID, WVALID, rsp_valid} !== 4'b1000)
         $display("FAIL rst_mid_abort {cmd_ready,AWVALID,WVALID,rsp_valid} got %b required 1000", {cmd_ready, AWVALID, WVALID, rsp_valid});
      else passed++;
   endtask

   task automatic test_read();
      ARREADY = 1;
      drive_cmd(0, 8'h10, 32'h0, 4'h0);
      sb.push_back('{wr: 1'b0, rdata: 32'hDEAD_BEEF, resp: 2'd0});
      @(negedge clk);                       // edge N accepted
      cmd_valid = 0;
      total++; if ({cmd_ready, ARVALID} !== 2'b01) $display("FAIL rd_arvalid {cmd_ready,ARVALID} got %b required 01", {cmd_ready, ARVALID}); else passed++;
      total++; if (ARADDR !== 8'h10) $display("FAIL rd_araddr got %h required 10", ARADDR); else passed++;
      @(negedge clk);                       // AR handshake at N+1
      ARREADY = 0;
      total++; if ({ARVALID, RREADY} !== 2'b01) $display("FAIL rd_rready {ARVALID,RREADY} got %b required 01", {ARVALID, RREADY}); else passed++;
      RVALID = 1; RDATA = 32'hDEAD_BEEF; RRESP = 2'd0;
      @(negedge clk);                       // R handshake at N+2
      RVALID = 0; RDATA = 0;
      total++; if (rsp_valid !== 1'b1) $display("FAIL rd_latency rsp_valid got %0b required 1 at N+3", rsp_valid); else passed++;
      wait_rsp();
   endtask

   task automatic test_write_aw_first();
      AWREADY = 1;
      drive_cmd(1, 8'h20, 32'h1234_5678, 4'hF);
      sb.push_back('{wr: 1'b1, rdata: 32'h0, resp: 2'd0});
      @(negedge clk);
      cmd_valid = 0;
      total++; if ({AWVALID, WVALID} !== 2'b11) $display("FAIL wr_valids got %b required 11", {AWVALID, WVALID}); else passed++;
      total++;
      if ({AWADDR, WDATA, WSTRB} !== {8'h20, 32'h1234_5678, 4'hF})
         $display("FAIL wr_payload got %h/%h/%h required 20/12345678/f", AWADDR, WDATA, WSTRB);
      else passed++;
      @(negedge clk);                       // AW handshake at N+1
      AWREADY = 0; WREADY = 1;
      total++; if ({AWVALID, WVALID, BREADY} !== 3'b010) $display("FAIL wr_aw_first_hold got %b required 010", {AWVALID, WVALID, BREADY}); else passed++;
      @(negedge clk);                       // W handshake at N+2
      WREADY = 0;
      total++; if ({AWVALID, WVALID, BREADY} !== 3'b001) $display("FAIL wr_bready got %b required 001", {AWVALID, WVALID, BREADY}); else passed++;
      BVALID = 1; BRESP = 2'd0;
      @(negedge clk);                       // B handshake at N+3
      BVALID = 0;
      total++; if ({rsp_valid, BREADY} !== 2'b10) $display("FAIL wr_latency {rsp_valid,BREADY} got %b required 10", {rsp_valid, BREADY}); else passed++;
      wait_rsp();
   endtask

   // both=1: AW and W accepted on the same edge; both=0: W before AW.
   task automatic test_write_order(input logic both);
      drive_cmd(1, 8'h24, 32'hA5A5_0001, 4'h6);
      sb.push_back('{wr: 1'b1, rdata: 32'h0, resp: 2'd1});
      @(negedge clk);
      cmd_valid = 0;
      WREADY = 1; AWREADY = both;
      @(negedge clk);
      WREADY = 0; AWREADY = 0;
      if (!both) begin
         total++; if ({AWVALID, WVALID, BREADY} !== 3'b100) $display("FAIL wr_w_first_hold got %b required 100", {AWVALID, WVALID, BREADY}); else passed++;
         AWREADY = 1;
         @(negedge clk);
         AWREADY = 0;
      end
      total++; if ({AWVALID, WVALID, BREADY} !== 3'b001) $display("FAIL wr_order_bready both=%0b got %b required 001", both, {AWVALID, WVALID, BREADY}); else passed++;
      BVALID = 1; BRESP = 2'd1;
      @(negedge clk);
      BVALID = 0;
      total++; if ({rsp_valid, BREADY} !== 2'b10) $display("FAIL wr_order_single_b both=%0b got %b required 10", both, {rsp_valid, BREADY}); else passed++;
      wait_rsp();
   endtask

   task automatic test_backpressure();
      drive_cmd(0, 8'h30, 32'h0, 4'h0);
      sb.push_back('{wr: 1'b0, rdata: 32'hCAFE_F00D, resp: 2'd0});
      @(negedge clk);
      // a stray write request stays asserted for the whole transaction
      drive_cmd(1, 8'h99, 32'hFFFF_FFFF, 4'hF);
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({ARVALID, ARADDR, cmd_ready} !== {1'b1, 8'h30, 1'b0})
            $display("FAIL bp_ar_hold cyc%0d ARVALID=%0b ARADDR=%h cmd_ready=%0b required 1/30/0", i, ARVALID, ARADDR, cmd_ready);
         else passed++;
         if (i < 2) @(negedge clk);
      end
      ARREADY = 1;
      @(negedge clk);
      ARREADY = 0;
      for (int i = 0; i < 5; i++) begin
         total++;
         if ({RREADY, ARVALID, cmd_ready, AWVALID} !== 4'b1000)
            $display("FAIL bp_r_wait cyc%0d got %b required 1000", i, {RREADY, ARVALID, cmd_ready, AWVALID});
         else passed++;
         @(negedge clk);
      end
      RVALID = 1; RDATA = 32'hCAFE_F00D; RRESP = 2'd0;
      @(negedge clk);
      RVALID = 0; RDATA = 0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({rsp_valid, rsp_write, rsp_rdata, rsp_resp, cmd_ready} !== {1'b1, 1'b0, 32'hCAFE_F00D, 2'd0, 1'b0})
            $display("FAIL bp_rsp_hold cyc%0d valid=%0b rdata=%h cmd_ready=%0b required 1/cafef00d/0", i, rsp_valid, rsp_rdata, cmd_ready);
         else passed++;
         @(negedge clk);
      end
      cmd_valid = 0;
      wait_rsp();
      @(negedge clk);
      total++; if ({ARVALID, AWVALID, cmd_ready} !== 3'b001) $display("FAIL bp_no_stray_cmd got %b required 001", {ARVALID, AWVALID, cmd_ready}); else passed++;
   endtask

   task automatic test_error_then_read();
      AWREADY = 1; WREADY = 1;
      drive_cmd(1, 8'h08, 32'h0000_0055, 4'h3);
      sb.push_back('{wr: 1'b1, rdata: 32'h0, resp: 2'b10});
      @(negedge clk);
      cmd_valid = 0;
      @(negedge clk);
      AWREADY = 0; WREADY = 0;
      BVALID = 1; BRESP = 2'b10;
      @(negedge clk);
      BVALID = 0; BRESP = 0;
      wait_rsp();
      ARREADY = 1;
      drive_cmd(0, 8'h04, 32'h0, 4'h0);
      sb.push_back('{wr: 1'b0, rdata: 32'h0000_0404, resp: 2'd0});
      @(negedge clk);
      cmd_valid = 0;
      total++; if (ARADDR !== 8'h04) $display("FAIL err_next_araddr got %h required 04", ARADDR); else passed++;
      @(negedge clk);
      ARREADY = 0;
      RVALID = 1; RDATA = 32'h0000_0404; RRESP = 2'd0;
      @(negedge clk);
      RVALID = 0;
      wait_rsp();
   endtask

   initial begin
      quiet_inputs();
      rst = 1;
      @(negedge clk);
      test_reset();
      test_read();
      test_write_aw_first();
      test_write_order(1'b0);
      test_write_order(1'b1);
      test_backpressure();
      test_error_then_read();
      test_reset_mid_write();
      total++;
      if (sb.size() != 0) $display("FAIL sb_drain %0d responses missing, required 0", sb.size()); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
